// File: rtl/ztonxor_gen_pkg.sv
// Shared constants for the range-XOR slice: instruction bus encodings used by the
// endpoint-stage decoders, and the producer's FSM state encoding.
package ztonxor_gen_pkg;

    typedef enum logic [1:0] {
        INST_NOP  = 2'b00,
        INST_SETL = 2'b01,
        INST_SETR = 2'b10,
        INST_CALC = 2'b11
    } inst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ztonxor_closed.sv
// Combinational f(n) = 0 ^ 1 ^ ... ^ n using the period-4 pattern of the prefix XOR.
module ztonxor_closed #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] f
);

    // The n+1 term cannot overflow: n mod 4 = 2 keeps n below the all-ones value.
    always_comb begin
        f = '0;
        case (n[1:0])
            2'd0: f = n;
            2'd1: f = WIDTH'(1);
            2'd2: f = n + WIDTH'(1);
            2'd3: f = '0;
        endcase
    end

endmodule

// File: rtl/ztonxor_gen.sv
// Sequences the prefix-XOR computation f(n) and holds the result on ztonxor for
// the endpoint registers; FAST selects iterative accumulation or the closed form.
module ztonxor_gen
    import ztonxor_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit FAST  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] ztonxor
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] closed_f;
    logic [WIDTH-1:0] acc_nxt;
    logic             last_run;

    ztonxor_closed #(.WIDTH(WIDTH)) u_closed (
        .n (n_q),
        .f (closed_f)
    );

    // Compare before increment, so n_q = all-ones terminates without i wrapping.
    assign last_run = (state == ST_RUN) && (FAST || (i_q == n_q));
    assign acc_nxt  = FAST ? closed_f : (acc ^ i_q);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_run) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            n_q     <= '0;
            acc     <= '0;
            i_q     <= '0;
            valid   <= 1'b0;
            ztonxor <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        acc   <= '0;
                        i_q   <= '0;
                        valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    // Load the result on entry to DONE so it is valid alongside the done pulse.
                    if (last_run) begin
                        ztonxor <= acc_nxt;
                        valid   <= 1'b1;
                    end else begin
                        i_q <= i_q + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ztonxor_gen.sv
// Directed and randomized checks of ztonxor_gen in both FAST modes against a
// loop-based prefix-XOR reference model.
module tb_ztonxor_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start0, start1;
    logic [W-1:0] n0, n1;
    logic         busy0, done0, valid0;
    logic         busy1, done1, valid1;
    logic [W-1:0] z0, z1;
    logic [W-1:0] cn, cf;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ztonxor_gen #(.WIDTH(W), .FAST(1'b0)) dut0 (
        .clk     (clk),
        .reset   (reset),
        .start   (start0),
        .n       (n0),
        .busy    (busy0),
        .done    (done0),
        .valid   (valid0),
        .ztonxor (z0)
    );

    ztonxor_gen #(.WIDTH(W), .FAST(1'b1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .start   (start1),
        .n       (n1),
        .busy    (busy1),
        .done    (done1),
        .valid   (valid1),
        .ztonxor (z1)
    );

    ztonxor_closed #(.WIDTH(W)) u_closed (
        .n (cn),
        .f (cf)
    );

    function automatic logic [W-1:0] xor_upto(input int nv);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k <= nv; k++) r = r ^ W'(k);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts a FAST=0 computation from IDLE, waits for done, then steps back into IDLE.
    task automatic run0(input logic [W-1:0] nv);
        int    lat;
        string tag;
        tag    = $sformatf("iter n=%0d", nv);
        n0     = nv;
        start0 = 1'b1;
        step;
        start0 = 1'b0;
        n0     = ~nv;
        check({tag, " valid cleared"}, valid0, 1'b0);
        lat = 1;
        while (done0 !== 1'b1 && lat < 300) begin
            step;
            lat++;
        end
        check({tag, " latency"}, lat, int'(nv) + 2);
        check({tag, " result"}, z0, xor_upto(int'(nv)));
        check({tag, " valid"}, valid0, 1'b1);
        check({tag, " busy in done"}, busy0, 1'b1);
        step;
        check({tag, " done one cycle"}, done0, 1'b0);
        check({tag, " idle"}, busy0, 1'b0);
        check({tag, " held"}, z0, xor_upto(int'(nv)));
    endtask

    initial begin
        int lat;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        n0     = '0;
        n1     = '0;
        cn     = '0;
        step;
        step;
        check("reset busy0", busy0, 1'b0);
        check("reset done0", done0, 1'b0);
        check("reset valid0", valid0, 1'b0);
        check("reset z0", z0, 8'd0);
        check("reset busy1", busy1, 1'b0);
        check("reset z1", z1, 8'd0);
        reset = 1'b0;
        step;

        run0(8'd5);
        run0(8'd0);
        run0(8'd3);
        run0(8'd6);

        // Start held high through RUN and DONE with a different n: all ignored.
        n0     = 8'd10;
        start0 = 1'b1;
        step;
        n0  = 8'd2;
        lat = 1;
        while (done0 !== 1'b1 && lat < 300) begin
            step;
            lat++;
        end
        check("busy-ignore latency", lat, 12);
        check("busy-ignore result", z0, 8'd11);
        step;
        start0 = 1'b0;
        check("start in done ignored", busy0, 1'b0);
        check("start in done held", z0, 8'd11);
        check("start in done valid", valid0, 1'b1);
        run0(8'd2);

        // Reset during the third RUN cycle discards the computation.
        n0     = 8'd20;
        start0 = 1'b1;
        step;
        start0 = 1'b0;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("mid-run reset busy", busy0, 1'b0);
        check("mid-run reset valid", valid0, 1'b0);
        check("mid-run reset z", z0, 8'd0);
        check("mid-run reset done", done0, 1'b0);
        run0(8'd4);

        run0(8'd255);
        repeat (8) run0(W'($urandom_range(0, 255)));

        for (int v = 0; v < 256; v++) begin
            n1     = W'(v);
            cn     = W'(v);
            start1 = 1'b1;
            step;
            start1 = 1'b0;
            lat    = 1;
            while (done1 !== 1'b1 && lat < 10) begin
                step;
                lat++;
            end
            check($sformatf("fast n=%0d latency", v), lat, 2);
            check($sformatf("fast n=%0d result", v), z1, xor_upto(v));
            check($sformatf("closed n=%0d", v), cf, xor_upto(v));
            check($sformatf("fast n=%0d valid", v), valid1, 1'b1);
            step;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
